mdu: RTL and testbench
======================

# mdu

Iterative multiply/divide unit for the EX stage. It executes MULT, MULTU, DIV and DIVU over a fixed 32-iteration sequence and owns the architectural HI/LO registers, including MTHI/MTLO writes. It sits beside the single-cycle ALU. The pipeline stalls on `busy` and may abort an in-flight operation with `flush`.

## Interface
- `WIDTH`, default 32: operand width. Iteration count equals `WIDTH`.
- `clk` input 1: clock. All state changes on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `start` input 1: request a new operation. Sampled only in IDLE or DONE.
- `func` input 2: operation select. 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- `srca` input 32: multiplicand or dividend.
- `srcb` input 32: multiplier or divisor.
- `flush` input 1: synchronous abort of the current operation.
- `hi_we` input 1: MTHI write enable.
- `lo_we` input 1: MTLO write enable.
- `wdata` input 32: data for MTHI/MTLO.
- `busy` output 1: high while in CALC.
- `done` output 1: one-cycle completion pulse.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- **Reset:** state = IDLE, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, iteration counter = 0.
- **IDLE:**
  - `start` = 1 and `flush` = 0: latch `func`, `srca`, `srcb`, load the working registers, counter = 0, go to CALC.
- **CALC:** one iteration per edge.
  - When counter = 31, write the result into `hi`/`lo` and go to DONE.
  - Otherwise increment the counter.
- **DONE:**
  - `done` = 1 for exactly one cycle, then go to IDLE.
  - `start` = 1 in DONE is accepted exactly as in IDLE, going straight to CALC (back-to-back operations).
- **Multiply:** shift-add on operand magnitudes, producing a 64-bit product.
  - MULT negates the product when the operand signs differ.
  - MULTU uses raw operands.
  - `hi` = product[63:32], `lo` = product[31:0].
- **Divide:** restoring division on operand magnitudes.
  - `lo` = quotient, `hi` = remainder.
  - DIV truncates the quotient toward zero; the remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0 (two's-complement wrap, no trap).
- **Divide by zero** (DIV or DIVU): full 32-iteration latency, then `lo` = 0xFFFFFFFF, `hi` = `srca`.
- **Flush:** `flush` = 1 in any state returns to IDLE on that edge.
  - `hi`/`lo` are unchanged and no `done` is produced.
  - `flush` wins over `start` in the same cycle.
- **MTHI/MTLO:** `hi_we`/`lo_we` write `wdata` on the edge only when not in CALC. In CALC they are ignored; the pipeline must not issue them while `busy`.
- **Write collision:** `hi_we`/`lo_we` in DONE take effect. Since the result was already written on the previous edge, the MT write is the final value.
- **Ignored inputs:** `start` while in CALC is ignored.
- **Reset mid-operation:** asynchronous return to the reset values above.

## Timing
- Let E0 be the edge that samples `start`.
  - CALC occupies edges E1..E32.
  - `hi`/`lo` hold the result and `done` = 1 in the cycle after E32.
  - State is IDLE after E33, or CALC again if `start` was sampled at E33.
- `busy` is high from after E0 through E32, exactly 32 cycles.
- `busy` and `done` are registered outputs and never high together.
- Initiation interval: 33 cycles back-to-back.
- `hi`/`lo` change only at the result edge, an MT write edge, or reset.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - `busy` is high for 32 cycles, `done` pulses once.
  - `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
- MULT 0xFFFFFFFD (−3) × 0x00000005: `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1.
- Signed divide:
  - DIV 0xFFFFFFF9 (−7) / 0x00000002: `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
  - Then DIV 0x80000000 / 0xFFFFFFFF issued in the DONE cycle: accepted back-to-back, giving `lo` = 0x80000000, `hi` = 0.
- DIVU 0x00000007 / 0: same latency, `lo` = 0xFFFFFFFF, `hi` = 0x00000007.
- Flush and MT write:
  - Preload `hi` = 0x11111111 via MTHI.
  - Start DIVU 100 / 7, assert `flush` at E10.
  - Required: `busy` low after E10, no `done`, `hi` still 0x11111111.
  - `hi_we` during CALC has no effect.
- Reset mid-operation: drop `resetn` at E15 of a MULTU. `busy`, `done`, `hi` and `lo` go to 0 immediately, without waiting for a clock edge. A new MULTU 6 × 7 after release gives `lo` = 42, `hi` = 0.

Source files
------------

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - request/result bundle between the EX stage and the multiply/divide unit
interface mdu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       func;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, func, srca, srcb, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, func, srca, srcb, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
// Works on operand magnitudes for WIDTH iterations and applies signs at the result edge.
module mdu #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  resetn,
  mdu_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               op_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   dvs;
  logic [2*WIDTH-1:0] acc;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               sgn_a;
  logic               sgn_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] acc_nx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;

  // func[0] = 0 selects the signed variants
  assign sgn_a = ~bus.func[0] & bus.srca[WIDTH-1];
  assign sgn_b = ~bus.func[0] & bus.srcb[WIDTH-1];
  assign mag_a = sgn_a ? -bus.srca : bus.srca;
  assign mag_b = sgn_b ? -bus.srcb : bus.srcb;

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
  always_comb begin
    msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    if (!op_div)
      acc_nx = {msum, acc[WIDTH-1:1]};
    else if (!diff[WIDTH])
      acc_nx = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_nx = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    prod    = neg_q ? -acc_nx : acc_nx;
    quo_res = neg_q ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
    rem_res = neg_r ? -acc_nx[2*WIDTH-1:WIDTH] : acc_nx[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dvs    <= '0;
      acc    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      if (state != S_CALC) begin
        if (bus.hi_we) hi_r <= bus.wdata;
        if (bus.lo_we) lo_r <= bus.wdata;
      end
      if (bus.flush) begin
        state  <= S_IDLE;
        cnt    <= '0;
        busy_r <= 1'b0;
        done_r <= 1'b0;
      end else begin
        case (state)
          S_CALC: begin
            acc <= acc_nx;
            if (cnt == LAST) begin
              if (op_div) begin
                hi_r <= rem_res;
                lo_r <= quo_res;
              end else begin
                hi_r <= prod[2*WIDTH-1:WIDTH];
                lo_r <= prod[WIDTH-1:0];
              end
              state  <= S_DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            done_r <= 1'b0;
            if (bus.start) begin
              state  <= S_CALC;
              cnt    <= '0;
              busy_r <= 1'b1;
              op_div <= bus.func[1];
              // a zero divisor keeps the all-ones quotient unsigned
              neg_q  <= (sgn_a ^ sgn_b) & ~(bus.func[1] & (bus.srcb == '0));
              neg_r  <= bus.func[1] & sgn_a;
              dvs    <= mag_b;
              acc    <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              state <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - randomized and directed check of mdu against an arithmetic reference
module tb_mdu;
  logic clk = 1'b0;
  logic resetn;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mdu_if #(.WIDTH(32)) bus ();

  mdu #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // returns {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] t;
    logic [31:0] q, r;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      2'b00: begin
        sq = sa * sb;
        t = sq;
      end
      2'b01: t = {32'h0, a} * {32'h0, b};
      default: begin
        if (b == 32'h0) begin
          t = {a, 32'hFFFF_FFFF};
        end else if (f == 2'b10) begin
          sq = sa / sb;
          sr = sa % sb;
          q = sq[31:0];
          r = sr[31:0];
          t = {r, q};
        end else begin
          q = a / b;
          r = a % b;
          t = {r, q};
        end
      end
    endcase
    return t;
  endfunction

  task automatic launch(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.func  = f;
    bus.srca  = a;
    bus.srcb  = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // called at the negedge after the start edge; returns at the negedge of the done cycle
  task automatic finish_op(input string tag, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    int nb = 0;
    int guard = 0;
    int both = 0;
    while (!bus.done && guard < 40) begin
      if (bus.busy) nb++;
      @(negedge clk);
      guard++;
    end
    if (bus.busy && bus.done) both = 1;
    check({tag, ".done"}, 64'(bus.done), 64'd1);
    check({tag, ".busy_cycles"}, 64'(nb), 64'd32);
    check({tag, ".busy_done_overlap"}, 64'(both), 64'd0);
    check({tag, ".hilo"}, {bus.hi, bus.lo}, model(f, a, b));
  endtask

  initial begin
    logic [1:0]  f;
    logic [31:0] a, b, lo_keep;
    int seen;

    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.func  = 2'b00;
    bus.srca  = '0;
    bus.srcb  = '0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (2) @(negedge clk);
    check("reset.busy", 64'(bus.busy), 64'd0);
    check("reset.done", 64'(bus.done), 64'd0);
    check("reset.hi", 64'(bus.hi), 64'd0);
    check("reset.lo", 64'(bus.lo), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max.const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    check("multu_max.done_pulse", 64'(bus.done), 64'd0);
    check("multu_max.idle_busy", 64'(bus.busy), 64'd0);

    launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
    finish_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
    check("mult_neg.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    @(negedge clk);

    launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    finish_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    check("div_neg.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("b2b.busy", 64'(bus.busy), 64'd1);
    finish_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf.const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    bus.lo_we = 1'b1;
    bus.wdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mtlo_in_done.lo", 64'(bus.lo), 64'hCAFE_F00D);
    check("mtlo_in_done.hi", 64'(bus.hi), 64'h0);

    launch(2'b11, 32'h0000_0007, 32'h0000_0000);
    finish_op("divu_zero", 2'b11, 32'h0000_0007, 32'h0000_0000);
    check("divu_zero.const", {bus.hi, bus.lo}, 64'h0000_0007_FFFF_FFFF);
    @(negedge clk);

    bus.hi_we = 1'b1;
    bus.wdata = 32'h1111_1111;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mthi.hi", 64'(bus.hi), 64'h1111_1111);
    lo_keep = bus.lo;
    launch(2'b11, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mthi_in_calc.hi", 64'(bus.hi), 64'h1111_1111);
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush.busy", 64'(bus.busy), 64'd0);
    seen = 0;
    repeat (40) begin
      if (bus.done || bus.busy) seen = 1;
      @(negedge clk);
    end
    check("flush.no_done", 64'(seen), 64'd0);
    check("flush.hi", 64'(bus.hi), 64'h1111_1111);
    check("flush.lo", 64'(bus.lo), 64'(lo_keep));

    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_reset.busy", 64'(bus.busy), 64'd0);
    check("async_reset.done", 64'(bus.done), 64'd0);
    check("async_reset.hi", 64'(bus.hi), 64'd0);
    check("async_reset.lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    launch(2'b01, 32'd6, 32'd7);
    finish_op("multu_6x7", 2'b01, 32'd6, 32'd7);
    check("multu_6x7.const", {bus.hi, bus.lo}, 64'd42);

    for (int i = 0; i < 24; i++) begin
      f = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        3: a = 32'h8000_0000;
        default: ;
      endcase
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      launch(f, a, b);
      finish_op($sformatf("rand%0d", i), f, a, b);
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
